mem_port_arbiter: RTL and testbench

//  Shares the single main-memory port between I-cache and D-cache miss handling.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_burst_addr_gen.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encodings and
// grant identities, also used by the cache controllers.
package mem_port_arbiter_pkg;

    localparam int unsigned BURST_LEN_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST_I = 2'd1,
        ST_BURST_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_burst_addr_gen.sv
// Beat counter and word-address generator for one cache-line burst.
// The beat index wraps inside the line, so the base is never carried into.
module burst_addr_gen #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         advance,
    input  logic [31:0]                  base_in,
    output logic [$clog2(BURST_LEN)-1:0] beat,
    output logic [31:0]                  addr,
    output logic                         last
);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned LINE_LSB = 2 + BEAT_W;

    logic [31-LINE_LSB:0] base_q, base_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 unused_base_bits;

    assign unused_base_bits = ^base_in[LINE_LSB-1:0];

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        base_d = base_q;
        beat_d = beat_q;
        if (load) begin
            base_d = base_in[31:LINE_LSB];
            beat_d = '0;
        end else if (advance) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments, so all flops update together on the edge.
        if (!rst_n) begin
            base_q <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
        end
    end

    assign beat = beat_q;
    assign last = &beat_q;
    assign addr = {base_q, beat_q, 2'b00};

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single main-memory port, sequencing I-cache refill
// bursts and D-cache refill/write-back bursts, and producing pipeline stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [31:0]                  i_addr,
    output logic                         i_rvalid,
    output logic [31:0]                  i_rdata,
    output logic [$clog2(BURST_LEN)-1:0] i_beat,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [31:0]                  d_addr,
    input  logic [31:0]                  d_wdata,
    output logic                         d_rvalid,
    output logic [31:0]                  d_rdata,
    output logic [$clog2(BURST_LEN)-1:0] d_beat,
    output logic                         d_done,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ready,
    input  logic [31:0]                  mem_rdata,
    output logic                         stall_if,
    output logic                         stall_mem
);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);

    arb_state_e  state_q, state_d;
    gnt_e        last_gnt_q, last_gnt_d;
    logic        we_q, we_d;
    logic        mem_req_q, mem_req_d;
    logic        i_rvalid_q, i_rvalid_d, i_done_q, i_done_d;
    logic        d_rvalid_q, d_rvalid_d, d_done_q, d_done_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    logic              gen_load, gen_advance, gen_last;
    logic [31:0]       gen_base, gen_addr;
    logic [BEAT_W-1:0] gen_beat;
    logic              i_pending, d_pending, grant_d;

    // A requester only drops its request after seeing done, so the done
    // cycle must not count as a fresh request (this also forces the idle gap).
    assign i_pending = i_req & ~i_done_q;
    assign d_pending = d_req & ~d_done_q;
    assign grant_d   = (i_pending & d_pending) ? (last_gnt_q == GNT_I) : d_pending;
    assign gen_base  = grant_d ? d_addr : i_addr;

    burst_addr_gen #(.BURST_LEN(BURST_LEN)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gen_load),
        .advance (gen_advance),
        .base_in (gen_base),
        .beat    (gen_beat),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        mem_req_d   = mem_req_q;
        i_rvalid_d  = 1'b0;
        i_rdata_d   = '0;
        i_done_d    = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = '0;
        d_done_d    = 1'b0;
        gen_load    = 1'b0;
        gen_advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_pending | d_pending) begin
                    gen_load   = 1'b1;
                    mem_req_d  = 1'b1;
                    state_d    = grant_d ? ST_BURST_D : ST_BURST_I;
                    last_gnt_d = grant_d ? GNT_D : GNT_I;
                    we_d       = grant_d & d_we;
                end
            end
            ST_BURST_I, ST_BURST_D: begin
                if (mem_ready) begin
                    gen_advance = 1'b1;
                    if (!we_q) begin
                        if (state_q == ST_BURST_I) begin
                            i_rvalid_d = 1'b1;
                            i_rdata_d  = mem_rdata;
                        end else begin
                            d_rvalid_d = 1'b1;
                            d_rdata_d  = mem_rdata;
                        end
                    end
                    if (gen_last) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        we_d      = 1'b0;
                        i_done_d  = (state_q == ST_BURST_I);
                        d_done_d  = (state_q == ST_BURST_D);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_I;
            we_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_done_q   <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            mem_req_q  <= mem_req_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_done_q   <= i_done_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_done_q   <= d_done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = mem_req_q ? gen_addr : '0;
    assign mem_wdata = we_q ? d_wdata : '0;

    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign i_beat    = (state_q == ST_BURST_I) ? gen_beat : '0;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_beat    = (state_q == ST_BURST_D) ? gen_beat : '0;

    assign stall_if  = i_pending;
    assign stall_mem = d_pending;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; each burst is checked
// beat by beat against a transaction-level model of grants, addresses and data.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [1:0]  i_beat;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [1:0]  d_beat;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;

    int vectors = 0;
    int miscompares = 0;
    bit last_was_d = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_beat    (i_beat),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_beat    (d_beat),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_C3A5;
    endfunction

    // Round robin: on a tie the requester that did not win last time goes.
    function automatic bit pick_d(input bit i, input bit d, input bit last_d);
        if (i && d) return !last_d;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_i_done", 32'(i_done), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_stall_if", 32'(stall_if), 32'(i_req));
        check("rst_stall_mem", 32'(stall_mem), 32'(d_req));
        tick();
        check("rst_hold_mem_req", 32'(mem_req), 32'd0);
        check("rst_hold_i_done", 32'(i_done), 32'd0);
        tick();
        rst_n = 1'b1;
        last_was_d = 1'b0;
    endtask

    // Called in the first cycle of beat b_first; returns in the cycle after
    // the ready of beat b_last (the done cycle when b_last is the final beat).
    task automatic serve(input bit is_d, input logic [31:0] base, input bit we,
                         input logic [31:0] wseed, input int mode,
                         input int b_first, input int b_last);
        logic [31:0] line, ea, rd, wd;
        bit rdy;
        bit last_beat;
        line = base & 32'hFFFF_FFF0;
        for (int b = b_first; b <= b_last; b++) begin
            ea = line + 32'(4 * b);
            rd = mem_model(ea);
            wd = wseed + 32'(b);
            for (int w = 0; w < 8; w++) begin
                rdy = (mode == 0) || (mode == 1 && w == 2) ||
                      (mode == 2 && (w == 4 || $urandom_range(0, 2) == 0));
                mem_ready = rdy;
                mem_rdata = rdy ? rd : ~rd;
                d_wdata   = (is_d && we) ? wd : 32'hFFFF_FFFF;
                #1;
                check("mem_req", 32'(mem_req), 32'd1);
                check("mem_addr", mem_addr, ea);
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_wdata", mem_wdata, (is_d && we) ? wd : 32'd0);
                check("i_beat", 32'(i_beat), is_d ? 32'd0 : 32'(b));
                check("d_beat", 32'(d_beat), is_d ? 32'(b) : 32'd0);
                check("stall_if", 32'(stall_if), 32'(i_req));
                check("stall_mem", 32'(stall_mem), 32'(d_req));
                tick();
                if (rdy) break;
            end
            last_beat = (b == 3);
            check("i_rvalid", 32'(i_rvalid), 32'(!is_d && !we));
            check("d_rvalid", 32'(d_rvalid), 32'(is_d && !we));
            if (!we) check(is_d ? "d_rdata" : "i_rdata", is_d ? d_rdata : i_rdata, rd);
            check("i_done", 32'(i_done), 32'(!is_d && last_beat));
            check("d_done", 32'(d_done), 32'(is_d && last_beat));
            if (last_beat) begin
                check("stall_if_done", 32'(stall_if), 32'(i_req && is_d));
                check("stall_mem_done", 32'(stall_mem), 32'(d_req && !is_d));
            end
        end
        mem_ready = 1'b0;
        d_wdata   = '0;
    endtask

    initial begin
        bit own_d;
        bit mask_i;
        bit mask_d;
        int sel;
        logic [31:0] seed;

        #1;
        do_reset();

        // Lone I refill, unaligned base, memory always ready.
        i_req = 1'b1; i_addr = 32'h0000_1004;
        #1;
        check("i_grant_gap", 32'(mem_req), 32'd0);
        check("i_stall_wait", 32'(stall_if), 32'd1);
        tick();
        serve(1'b0, i_addr, 1'b0, 32'd0, 0, 0, 3);
        last_was_d = 1'b0;
        i_req = 1'b0;
        tick();
        check("idle_after_i", 32'(mem_req), 32'd0);
        check("stall_if_after", 32'(stall_if), 32'd0);

        // D write-back, ready every third cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000;
        #1;
        check("d_grant_gap", 32'(mem_req), 32'd0);
        tick();
        serve(1'b1, d_addr, 1'b1, 32'h0000_00A0, 1, 0, 3);
        last_was_d = 1'b1;
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("idle_after_d", 32'(mem_req), 32'd0);
        check("no_second_done", 32'(d_done), 32'd0);

        // Simultaneous requests from reset, both held: D, I, D, I.
        do_reset();
        i_addr = 32'h0000_3000; d_addr = 32'h0000_4008; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        #1;
        check("tie_grant_gap", 32'(mem_req), 32'd0);
        tick();
        mask_i = 1'b0; mask_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            own_d = pick_d(i_req && !mask_i, d_req && !mask_d, last_was_d);
            serve(own_d, own_d ? d_addr : i_addr, 1'b0, 32'd0, 2, 0, 3);
            last_was_d = own_d;
            mask_i = !own_d;
            mask_d = own_d;
            if (k == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            tick();
        end
        check("idle_after_alt", 32'(mem_req), 32'd0);

        // D refill at the top of the address space.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFFFF_FFF0;
        #1;
        tick();
        serve(1'b1, d_addr, 1'b0, 32'd0, 0, 0, 3);
        last_was_d = 1'b1;
        d_req = 1'b0;
        tick();
        check("idle_after_top", 32'(mem_req), 32'd0);

        // Reset during beat 2 of an I burst with a D request pending.
        i_req = 1'b1; i_addr = 32'h0000_5000;
        #1;
        tick();
        serve(1'b0, i_addr, 1'b0, 32'd0, 0, 0, 1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000;
        #1;
        check("abort_beat2_addr", mem_addr, 32'h0000_5008);
        do_reset();
        i_req = 1'b0;
        #1;
        check("post_rst_gap", 32'(mem_req), 32'd0);
        tick();
        serve(1'b1, d_addr, 1'b0, 32'd0, 2, 0, 3);
        last_was_d = 1'b1;
        d_req = 1'b0;
        tick();
        check("idle_after_abort", 32'(mem_req), 32'd0);

        // D request arriving in the middle of an I burst.
        i_req = 1'b1; i_addr = 32'h0000_7000;
        #1;
        tick();
        serve(1'b0, i_addr, 1'b0, 32'd0, 1, 0, 1);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_8000;
        serve(1'b0, i_addr, 1'b0, 32'd0, 1, 2, 3);
        last_was_d = 1'b0;
        i_req = 1'b0;
        #1;
        check("d_wait_stall", 32'(stall_mem), 32'd1);
        check("d_wait_idle", 32'(mem_req), 32'd0);
        tick();
        serve(1'b1, d_addr, 1'b1, 32'h0000_00B0, 1, 0, 3);
        last_was_d = 1'b1;
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("idle_after_mid", 32'(mem_req), 32'd0);

        // Randomized request mixes, addresses, directions and ready timing.
        for (int t = 0; t < 24; t++) begin
            sel    = int'($urandom_range(0, 2));
            i_addr = $urandom;
            d_addr = $urandom;
            d_we   = 1'($urandom_range(0, 1));
            seed   = $urandom;
            i_req  = (sel != 1);
            d_req  = (sel != 0);
            #1;
            check("rnd_grant_gap", 32'(mem_req), 32'd0);
            tick();
            own_d = pick_d(i_req, d_req, last_was_d);
            serve(own_d, own_d ? d_addr : i_addr, own_d && d_we, seed, 2, 0, 3);
            last_was_d = own_d;
            if (own_d) d_req = 1'b0;
            else       i_req = 1'b0;
            if (i_req || d_req) begin
                tick();
                own_d = pick_d(i_req, d_req, last_was_d);
                serve(own_d, own_d ? d_addr : i_addr, own_d && d_we, seed, 2, 0, 3);
                last_was_d = own_d;
                i_req = 1'b0;
                d_req = 1'b0;
            end
            d_we = 1'b0;
            tick();
            check("rnd_idle", 32'(mem_req), 32'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
